// File: rtl/mac_pkg.sv
// Shared types, result bounds and the round/saturate helper for the output-stationary MAC PE.
package mac_pkg;

  // The helper works at a fixed maximum width so any legal PE parameterisation can reuse it.
  localparam int unsigned AccMaxW = 128;
  localparam int unsigned OutMaxW = 64;
  localparam int unsigned OutDefW = 32;

  localparam logic signed [OutDefW-1:0] ResMax = {1'b0, {(OutDefW-1){1'b1}}};
  localparam logic signed [OutDefW-1:0] ResMin = {1'b1, {(OutDefW-1){1'b0}}};

  typedef struct packed {
    logic signed [OutMaxW-1:0] result;
    logic                      sat;
    logic                      valid;
  } res_t;

  typedef enum logic {AccEmpty = 1'b0, AccRun = 1'b1} acc_state_e;

  function automatic res_t round_sat(input logic signed [AccMaxW-1:0] sum,
                                     input int unsigned               frac_bits,
                                     input int unsigned               out_width);
    logic signed [AccMaxW-1:0] half;
    logic signed [AccMaxW-1:0] r;
    logic signed [AccMaxW-1:0] hi;
    logic signed [AccMaxW-1:0] lo;
    res_t                      o;
    half = '0;
    r    = sum;
    if (frac_bits > 0) begin
      half[frac_bits-1] = 1'b1;
      r = (sum + half) >>> frac_bits;
    end
    for (int unsigned i = 0; i < AccMaxW; i++) begin
      hi[i] = (i + 1 < out_width);
    end
    lo      = ~hi;
    o.valid = 1'b1;
    if (r > hi) begin
      o.result = hi[OutMaxW-1:0];
      o.sat    = 1'b1;
    end else if (r < lo) begin
      o.result = lo[OutMaxW-1:0];
      o.sat    = 1'b1;
    end else begin
      o.result = r[OutMaxW-1:0];
      o.sat    = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/mac_res_cell.sv
// Result holding register with capture-over-shift priority and sticky overrun detection.
module mac_res_cell #(
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cap_i,
  input  logic [OUT_WIDTH-1:0] cap_res_i,
  input  logic                 cap_sat_i,
  input  logic                 shift_en_i,
  input  logic [OUT_WIDTH-1:0] res_i,
  input  logic                 res_valid_i,
  input  logic                 res_sat_i,
  output logic [OUT_WIDTH-1:0] res_o,
  output logic                 res_valid_o,
  output logic                 res_sat_o,
  output logic                 overrun_o
);

  logic [OUT_WIDTH-1:0] res_d, res_q;
  logic                 vld_d, vld_q;
  logic                 sat_d, sat_q;
  logic                 ovr_d, ovr_q;

  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    sat_d = sat_q;
    ovr_d = ovr_q;
    if (cap_i) begin
      res_d = cap_res_i;
      sat_d = cap_sat_i;
      vld_d = 1'b1;
      // During a shift the value lost is the incoming upstream one, not the held one.
      if (shift_en_i ? res_valid_i : vld_q) ovr_d = 1'b1;
    end else if (shift_en_i) begin
      res_d = res_i;
      sat_d = res_sat_i;
      vld_d = res_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
      ovr_q <= ovr_d;
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = vld_q;
  assign res_sat_o   = sat_q;
  assign overrun_o   = ovr_q;

endmodule

// File: rtl/mac_os_pe.sv
// Output-stationary MAC PE: framed dot products, optional product pipe, round/saturate, drain chain.
module mac_os_pe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned MULT_PIPE  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] weight_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  shift_en_i,
  input  logic [OUT_WIDTH-1:0]  res_i,
  input  logic                  res_valid_i,
  input  logic                  res_sat_i,
  output logic [OUT_WIDTH-1:0]  res_o,
  output logic                  res_valid_o,
  output logic                  res_sat_o,
  output logic                  overrun_o,
  output logic                  dbg_acc_run_o
);

  logic [DATA_WIDTH-1:0] data_q, weight_q;
  logic                  valid_q, last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q   <= '0;
      weight_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      last_q  <= last_i & valid_i;
      if (valid_i) begin
        data_q   <= data_i;
        weight_q <= weight_i;
      end
    end
  end

  assign data_o   = data_q;
  assign weight_o = weight_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;

  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    s_prod;
  logic                           s_valid, s_last;

  assign prod_full = $signed(data_i) * $signed(weight_i);
  assign prod_ext  = {{(ACC_WIDTH-2*DATA_WIDTH){prod_full[2*DATA_WIDTH-1]}}, prod_full};

  if (MULT_PIPE != 0) begin : g_pipe
    logic signed [ACC_WIDTH-1:0] prod_q;
    logic                        pvalid_q, plast_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prod_q   <= '0;
        pvalid_q <= 1'b0;
        plast_q  <= 1'b0;
      end else if (clear_i) begin
        prod_q   <= '0;
        pvalid_q <= 1'b0;
        plast_q  <= 1'b0;
      end else begin
        prod_q   <= prod_ext;
        pvalid_q <= valid_i;
        plast_q  <= last_i & valid_i;
      end
    end

    assign s_prod  = prod_q;
    assign s_valid = pvalid_q;
    assign s_last  = plast_q;
  end else begin : g_comb
    assign s_prod  = prod_ext;
    assign s_valid = valid_i;
    assign s_last  = last_i & valid_i;
  end

  logic signed [ACC_WIDTH-1:0] acc_q, sum;
  logic                        cap;

  assign sum = acc_q + s_prod;
  assign cap = s_valid & s_last & ~clear_i;

  // Restart on last keeps the next frame bubble-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (s_valid) begin
      acc_q <= s_last ? '0 : sum;
    end
  end

  res_t                    conv;
  logic                    unused_conv;
  logic signed [AccMaxW-1:0] sum_ext;

  assign sum_ext     = {{(AccMaxW-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
  assign conv        = round_sat(sum_ext, FRAC_BITS, OUT_WIDTH);
  assign unused_conv = ^conv;

  mac_res_cell #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_res_cell (
    .clk        (clk),
    .rstn       (rstn),
    .cap_i      (cap),
    .cap_res_i  (conv.result[OUT_WIDTH-1:0]),
    .cap_sat_i  (conv.sat),
    .shift_en_i (shift_en_i),
    .res_i      (res_i),
    .res_valid_i(res_valid_i),
    .res_sat_i  (res_sat_i),
    .res_o      (res_o),
    .res_valid_o(res_valid_o),
    .res_sat_o  (res_sat_o),
    .overrun_o  (overrun_o)
  );

  acc_state_e state_d, state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= AccEmpty;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i || cap) state_d = AccEmpty;
    else if (s_valid)   state_d = AccRun;
  end

  always_comb begin
    dbg_acc_run_o = 1'b0;
    if (state_q == AccRun) dbg_acc_run_o = 1'b1;
  end

endmodule

// File: tb/tb_mac_os_pe.sv
// Directed self-checking bench for mac_os_pe: vectors table plus multi-cycle sequences.
module tb_mac_os_pe;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main DUT (defaults: FRAC_BITS=8, MULT_PIPE=1)
  logic        clear = 0, valid = 0, last = 0, shift_en = 0, res_valid_in = 0, res_sat_in = 0;
  logic [15:0] data = 0, weight = 0;
  logic [31:0] res_in = 0;
  logic [15:0] data_o, weight_o;
  logic        valid_o, last_o, res_valid_o, res_sat_o, overrun_o, dbg_run;
  logic [31:0] res_o;

  mac_os_pe u_dut (
    .clk(clk), .rstn(rstn), .clear_i(clear), .valid_i(valid), .last_i(last),
    .data_i(data), .weight_i(weight), .data_o(data_o), .weight_o(weight_o),
    .valid_o(valid_o), .last_o(last_o), .shift_en_i(shift_en), .res_i(res_in),
    .res_valid_i(res_valid_in), .res_sat_i(res_sat_in), .res_o(res_o),
    .res_valid_o(res_valid_o), .res_sat_o(res_sat_o), .overrun_o(overrun_o),
    .dbg_acc_run_o(dbg_run)
  );

  // FRAC_BITS=0, combinational multiplier build
  logic        z_valid = 0, z_last = 0;
  logic [15:0] z_data = 0, z_weight = 0;
  logic [15:0] z_data_o, z_weight_o;
  logic        z_valid_o, z_last_o, z_res_valid_o, z_res_sat_o, z_overrun_o, z_dbg;
  logic [31:0] z_res_o;

  mac_os_pe #(.FRAC_BITS(0), .MULT_PIPE(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .clear_i(1'b0), .valid_i(z_valid), .last_i(z_last),
    .data_i(z_data), .weight_i(z_weight), .data_o(z_data_o), .weight_o(z_weight_o),
    .valid_o(z_valid_o), .last_o(z_last_o), .shift_en_i(1'b0), .res_i(32'd0),
    .res_valid_i(1'b0), .res_sat_i(1'b0), .res_o(z_res_o), .res_valid_o(z_res_valid_o),
    .res_sat_o(z_res_sat_o), .overrun_o(z_overrun_o), .dbg_acc_run_o(z_dbg)
  );

  // Three-PE column, index 0 at the top
  logic        c_valid = 0, c_last = 0, c_shift = 0;
  logic [15:0] c_data [3];
  logic [15:0] c_weight [3];
  logic [31:0] c_up_res [3];
  logic        c_up_vld [3];
  logic        c_up_sat [3];
  logic [31:0] c_res [3];
  logic        c_vld [3];
  logic        c_sat [3];
  logic        c_ovr [3];

  assign c_up_res[0] = '0;
  assign c_up_vld[0] = 1'b0;
  assign c_up_sat[0] = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_col
    logic [15:0] fd, fw;
    logic        fv, fl, dbg;
    if (g < 2) begin : g_link
      assign c_up_res[g+1] = c_res[g];
      assign c_up_vld[g+1] = c_vld[g];
      assign c_up_sat[g+1] = c_sat[g];
    end
    mac_os_pe u_pe (
      .clk(clk), .rstn(rstn), .clear_i(1'b0), .valid_i(c_valid), .last_i(c_last),
      .data_i(c_data[g]), .weight_i(c_weight[g]), .data_o(fd), .weight_o(fw),
      .valid_o(fv), .last_o(fl), .shift_en_i(c_shift), .res_i(c_up_res[g]),
      .res_valid_i(c_up_vld[g]), .res_sat_i(c_up_sat[g]), .res_o(c_res[g]),
      .res_valid_o(c_vld[g]), .res_sat_o(c_sat[g]), .overrun_o(c_ovr[g]),
      .dbg_acc_run_o(dbg)
    );
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int d, input int w, input logic v, input logic l);
    data   = d[15:0];
    weight = w[15:0];
    valid  = v;
    last   = l;
  endtask

  task automatic idle();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic drain();
    shift_en     = 1'b1;
    res_valid_in = 1'b0;
    res_in       = '0;
    step();
    shift_en = 1'b0;
  endtask

  function automatic longint sres(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  typedef struct {
    string  name;
    int     d;
    int     w;
    longint exp;
    logic   sat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{"rnd_1x128",      1,      128,    1,       1'b0};
    vecs[1] = '{"rnd_1x127",      1,      127,    0,       1'b0};
    vecs[2] = '{"rnd_m1x128",     -1,     128,    0,       1'b0};
    vecs[3] = '{"rnd_m1x129",     -1,     129,    -1,      1'b0};
    vecs[4] = '{"one_256x256",    256,    256,    256,     1'b0};
    vecs[5] = '{"minxmin",        -32768, -32768, 4194304, 1'b0};
    vecs[6] = '{"maxxmax",        32767,  32767,  4194048, 1'b0};
    for (int i = 0; i < 3; i++) begin
      c_data[i]   = '0;
      c_weight[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_res", sres(res_o), 0);
    chk("rst_res_valid", longint'(res_valid_o), 0);
    chk("rst_overrun", longint'(overrun_o), 0);
    chk("rst_valid_o", longint'(valid_o), 0);
    chk("rst_dbg", longint'(dbg_run), 0);
    rstn = 1'b1;
    step();

    // Forwarding; clear drops the beat from accumulation only
    drive(5, 6, 1, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("fwd_data", longint'(data_o), 5);
    chk("fwd_weight", longint'(weight_o), 6);
    chk("fwd_last", longint'(last_o), 1);
    drive(9, 9, 0, 1);
    step();
    chk("fwd_hold_data", longint'(data_o), 5);
    chk("fwd_valid_low", longint'(valid_o), 0);
    chk("fwd_last_ignored", longint'(last_o), 0);
    step();
    chk("cleared_beat_no_result", longint'(res_valid_o), 0);

    // Two-beat frame
    drive(256, 512, 1, 0);
    step();
    drive(768, 256, 1, 1);
    step();
    idle();
    chk("dbg_run", longint'(dbg_run), 1);
    chk("t1_not_yet", longint'(res_valid_o), 0);
    step();
    chk("t1_res", sres(res_o), 1280);
    chk("t1_valid", longint'(res_valid_o), 1);
    chk("t1_sat", longint'(res_sat_o), 0);
    chk("dbg_empty", longint'(dbg_run), 0);
    drain();
    chk("drain_empty", longint'(res_valid_o), 0);

    // Table of single-beat frames
    foreach (vecs[i]) begin
      drive(vecs[i].d, vecs[i].w, 1, 1);
      step();
      idle();
      step();
      chk({vecs[i].name, "_res"}, sres(res_o), vecs[i].exp);
      chk({vecs[i].name, "_sat"}, longint'(res_sat_o), longint'(vecs[i].sat));
      chk({vecs[i].name, "_valid"}, longint'(res_valid_o), 1);
      drain();
    end
    chk("no_overrun_yet", longint'(overrun_o), 0);

    // Back-to-back frames, drain strobe during the second capture
    drive(256, 256, 1, 1);
    step();
    drive(512, 256, 1, 1);
    step();
    idle();
    chk("b2b_first", sres(res_o), 256);
    shift_en = 1'b1;
    step();
    shift_en = 1'b0;
    chk("b2b_second", sres(res_o), 512);
    chk("b2b_valid", longint'(res_valid_o), 1);
    chk("b2b_no_overrun", longint'(overrun_o), 0);
    drain();

    // Shift loads upstream value when nothing is captured
    res_in = 32'd777; res_valid_in = 1'b1; res_sat_in = 1'b1; shift_en = 1'b1;
    step();
    shift_en = 1'b0; res_valid_in = 1'b0; res_sat_in = 1'b0;
    chk("shift_res", sres(res_o), 777);
    chk("shift_sat", longint'(res_sat_o), 1);
    drain();

    // Positive saturation: 512 * 2^30 = 2^39
    for (int i = 0; i < 512; i++) begin
      drive(-32768, -32768, 1, i == 511);
      step();
    end
    idle();
    step();
    chk("sat_pos_res", sres(res_o), longint'(ResMax));
    chk("sat_pos_flag", longint'(res_sat_o), 1);
    drain();

    // Negative near-limit: 512 * -(2^30-2^15) = -(2^39-2^24), >>>8 -> -(2^31-2^16)
    for (int i = 0; i < 512; i++) begin
      drive(-32768, 32767, 1, i == 511);
      step();
    end
    idle();
    step();
    chk("sat_neg_res", sres(res_o), -64'sd2147418112);
    chk("sat_neg_flag", longint'(res_sat_o), 0);
    chk("resmin_below", longint'(sres(res_o) > longint'(ResMin)), 1);
    drain();

    // FRAC_BITS=0, MULT_PIPE=0: one-cycle latency
    z_data = 16'd3; z_weight = 16'hfffb; z_valid = 1'b1; z_last = 1'b1;
    step();
    z_valid = 1'b0; z_last = 1'b0;
    chk("f0_res", sres(z_res_o), -15);
    chk("f0_valid", longint'(z_res_valid_o), 1);

    // Column drain
    c_data[0] = 16'd10; c_data[1] = 16'd20; c_data[2] = 16'd30;
    for (int i = 0; i < 3; i++) c_weight[i] = 16'd256;
    c_valid = 1'b1; c_last = 1'b1;
    step();
    c_valid = 1'b0; c_last = 1'b0;
    step();
    chk("col_tail0", sres(c_res[2]), 30);
    c_shift = 1'b1;
    step();
    chk("col_tail1", sres(c_res[2]), 20);
    step();
    chk("col_tail2", sres(c_res[2]), 10);
    step();
    c_shift = 1'b0;
    chk("col_tail_bubble", longint'(c_vld[2]), 0);
    chk("col_no_overrun", longint'(c_ovr[2]), 0);

    // Overrun: capture over an unread result, then sticky through drains
    drive(256, 256, 1, 1);
    step();
    idle();
    step();
    drive(256, 256, 1, 1);
    step();
    idle();
    step();
    chk("overrun_set", longint'(overrun_o), 1);
    drain();
    drain();
    chk("overrun_sticky", longint'(overrun_o), 1);

    // Clear mid-frame, including a valid beat in the clear cycle
    drive(1000, 1000, 1, 0);
    step();
    drive(1000, 1000, 1, 0);
    step();
    drive(100, 100, 1, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_fwd_data", longint'(data_o), 100);
    drive(2, 2, 1, 1);
    step();
    idle();
    step();
    chk("clear_res", sres(res_o), 0);
    chk("clear_valid", longint'(res_valid_o), 1);
    drain();

    // Async reset mid-frame
    drive(1000, 1000, 1, 0);
    step();
    drive(1000, 1000, 1, 0);
    step();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_overrun", longint'(overrun_o), 0);
    chk("arst_valid_o", longint'(valid_o), 0);
    chk("arst_data_o", longint'(data_o), 0);
    chk("arst_res_valid", longint'(res_valid_o), 0);
    chk("arst_dbg", longint'(dbg_run), 0);
    idle();
    @(negedge clk);
    rstn = 1'b1;
    drive(512, 256, 1, 1);
    step();
    idle();
    step();
    chk("post_rst_res", sres(res_o), 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
